armleocpu_writeback: RTL and testbench
======================================

// Module: armleocpu_writeback
// PURPOSE
// - Write side of the register file: merges results from the execute stage (exe) and the load/mul-div
//   unit (lsu) onto the single regfile write port (rd_addr/rd_wdata/rd_write), one write per cycle.
// - Holds a busy scoreboard for long-latency destinations and forwards the write stage onto the rs1/rs2
//   read paths, so decode sees current values and a stall indication.
// PARAMETERS
// - STARVE_LIMIT  default 4  consecutive stalled lsu cycles before lsu takes priority over exe (1..15)
// PORTS
// - clk               in   1   clock, all state updates on rising edge
// - rst               in   1   reset, synchronous, active-high
// - exe_valid         in   1   exe result present
// - exe_ready         out  1   exe result accepted this cycle
// - exe_rd            in   5   exe destination register
// - exe_wdata         in   32  exe result data
// - lsu_valid         in   1   lsu result present
// - lsu_ready         out  1   lsu result accepted this cycle
// - lsu_rd            in   5   lsu destination register
// - lsu_wdata         in   32  lsu result data
// - issue_valid       in   1   a long-latency op is issued this cycle (mark rd busy)
// - issue_rd          in   5   destination of the issued op
// - rs1_addr/rs2_addr in   5   read addresses (same values driven to the regfile)
// - rs1_regfile_rdata in   32  regfile rs1 read data; rs2_regfile_rdata likewise
// - rs1_rdata/rs2_rdata out 32 forwarded read data
// - rs1_busy/rs2_busy out  1   source register has a pending lsu write; decode must stall
// - sb_conflict       out  1   one-cycle pulse: issue to an already-busy rd
// - rd_addr           out  5   regfile write address (registered)
// - rd_wdata          out  32  regfile write data (registered)
// - rd_write          out  1   regfile write enable (registered)
// BEHAVIOUR
// - Reset (rst=1 at edge): rd_write=0, rd_addr=0, rd_wdata=0, sb_conflict=0, scoreboard all clear,
//   starve counter=0. Combinational outputs follow from that state.
// - Handshake: transfer on valid&&ready at an edge. valid/rd/wdata must hold until accepted.
// - Arbitration: starved = (starve_cnt == STARVE_LIMIT). lsu_ready = !exe_valid || starved;
//   exe_ready = !(lsu_valid && starved). Never both transfers in the same cycle.
// - starve_cnt: +1 each cycle lsu_valid && !lsu_ready, saturating at STARVE_LIMIT; cleared on lsu transfer.
// - Write stage latency 1: transfer at edge N -> rd_write=1, rd_addr/rd_wdata=source values during
//   cycle N..N+1; regfile updates at edge N+1. No transfer -> rd_write=0 next cycle.
// - rd==0 transfer: accepted, rd_write stays 0, no scoreboard change.
// - Scoreboard (31 bits, x0 never busy): issue_valid with issue_rd!=0 sets busy[issue_rd];
//   lsu transfer clears busy[lsu_rd]. Same cycle, same rd: set wins (new pending op).
//   issue to already-busy rd: stays busy, sb_conflict=1 next cycle. exe writes never touch busy.
// - rsX_busy = busy[rsX_addr] (combinational; 0 for x0).
// - Forwarding: rsX_rdata = (rd_write && rd_addr==rsX_addr && rsX_addr!=0) ? rd_wdata : rsX_regfile_rdata.
// - Reset mid-operation: pending write-stage entry dropped (rd_write=0), busy cleared, no ready
//   assertions change handshake rules (ready still combinational from valid/counter).
// STRUCTURE
// - armleocpu_wb_pkg: XLEN=32, REG_ADDR_W=5, REG_COUNT=32, typedef enum {WB_SRC_NONE, WB_SRC_EXE,
//   WB_SRC_LSU} wb_src_t.
// - Sub-module armleocpu_scoreboard: busy vector, set/clear ports, two combinational lookups,
//   conflict pulse. Top holds arbiter, starve counter, write-stage register, forwarding muxes.
// TESTING
// - Reset: hold rst 2 cycles with all valids=1 -> rd_write=0, all busy=0, sb_conflict=0 after release.
// - exe only: exe_valid=1 rd=5 wdata=0xDEADBEEF -> exe_ready=1; next cycle rd_write=1 rd_addr=5;
//   rs1_addr=5 that cycle -> rs1_rdata=0xDEADBEEF regardless of rs1_regfile_rdata.
// - Contention: exe_valid=1 every cycle, lsu_valid=1 rd=7; STARVE_LIMIT=4 -> lsu_ready=0 four cycles,
//   lsu accepted in 5th, exe_ready=0 that cycle; counter back to 0, exe resumes next cycle.
// - Scoreboard: issue rd=9 -> rs2_busy=1 for rs2_addr=9 until lsu transfer rd=9; same edge issue rd=9
//   again -> busy stays 1; issue rd=9 while busy -> sb_conflict pulse 1 cycle.
// - x0: exe rd=0 and issue rd=0 -> rd_write=0, rs1_busy=0, rs1_rdata=rs1_regfile_rdata for rs1_addr=0.
// - Reset mid-op: transfer at edge N, rst=1 at edge N+1 -> rd_write=0 after edge N+1, busy all 0.

Source files
------------

// File: rtl/armleocpu_wb_pkg.sv
// Shared constants and types for the register-file write side.
package armleocpu_wb_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 32;

    typedef enum logic [1:0] {
        WB_SRC_NONE,
        WB_SRC_EXE,
        WB_SRC_LSU
    } wb_src_t;
endpackage

// File: rtl/armleocpu_scoreboard.sv
// Busy bits for destinations with a pending long-latency (lsu) write.
// Bit 0 is never set, so x0 always reads as not busy.
module armleocpu_scoreboard
    import armleocpu_wb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_valid,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_valid,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  conflict
);
    logic [REG_COUNT-1:0] busy;
    logic [REG_COUNT-1:0] busy_next;
    logic                 set_en;
    logic                 clr_en;

    assign set_en = set_valid && (set_addr != '0);
    assign clr_en = clr_valid && (clr_addr != '0);

    // Clear applied before set: a new issue on the same edge keeps the register busy.
    always_comb begin
        busy_next = busy;
        if (clr_en)
            busy_next[clr_addr] = 1'b0;
        if (set_en)
            busy_next[set_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            conflict <= 1'b0;
        end else begin
            busy     <= busy_next;
            conflict <= set_en && busy[set_addr];
        end
    end

    assign rs1_busy = busy[rs1_addr];
    assign rs2_busy = busy[rs2_addr];
endmodule

// File: rtl/armleocpu_writeback.sv
// Register-file write port arbiter (exe vs lsu with starvation guard),
// one-cycle write stage, busy scoreboard and write-stage forwarding.
module armleocpu_writeback
    import armleocpu_wb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exe_valid,
    output logic                  exe_ready,
    input  logic [REG_ADDR_W-1:0] exe_rd,
    input  logic [XLEN-1:0]       exe_wdata,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_wdata,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [XLEN-1:0]       rs1_regfile_rdata,
    input  logic [XLEN-1:0]       rs2_regfile_rdata,
    output logic [XLEN-1:0]       rs1_rdata,
    output logic [XLEN-1:0]       rs2_rdata,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  sb_conflict,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic [XLEN-1:0]       rd_wdata,
    output logic                  rd_write
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic       starved;
    logic       exe_fire;
    logic       lsu_fire;
    wb_src_t    wb_src;

    // Handshake: a result transfers at a rising edge where valid && ready;
    // the source holds valid/rd/wdata until then. Ready depends only on
    // valids and the starve counter, so the two transfers are exclusive.
    assign starved   = (starve_cnt == LIMIT);
    assign lsu_ready = !exe_valid || starved;
    assign exe_ready = !(lsu_valid && starved);
    assign exe_fire  = exe_valid && exe_ready;
    assign lsu_fire  = lsu_valid && lsu_ready;

    always_comb begin
        wb_src = WB_SRC_NONE;
        if (lsu_fire)
            wb_src = WB_SRC_LSU;
        else if (exe_fire)
            wb_src = WB_SRC_EXE;
    end

    always_ff @(posedge clk) begin
        if (rst)
            starve_cnt <= '0;
        else if (lsu_fire)
            starve_cnt <= '0;
        else if (lsu_valid && !starved)
            starve_cnt <= starve_cnt + 4'd1;
    end

    // x0 transfers are consumed but never raise the write enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_write <= 1'b0;
            rd_addr  <= '0;
            rd_wdata <= '0;
        end else begin
            case (wb_src)
                WB_SRC_LSU: begin
                    rd_write <= (lsu_rd != '0);
                    rd_addr  <= lsu_rd;
                    rd_wdata <= lsu_wdata;
                end
                WB_SRC_EXE: begin
                    rd_write <= (exe_rd != '0);
                    rd_addr  <= exe_rd;
                    rd_wdata <= exe_wdata;
                end
                default: rd_write <= 1'b0;
            endcase
        end
    end

    assign rs1_rdata = (rd_write && (rd_addr == rs1_addr) && (rs1_addr != '0)) ? rd_wdata : rs1_regfile_rdata;
    assign rs2_rdata = (rd_write && (rd_addr == rs2_addr) && (rs2_addr != '0)) ? rd_wdata : rs2_regfile_rdata;

    armleocpu_scoreboard u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_valid (issue_valid),
        .set_addr  (issue_rd),
        .clr_valid (lsu_fire),
        .clr_addr  (lsu_rd),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .conflict  (sb_conflict)
    );
endmodule

// File: tb/tb_armleocpu_writeback.sv
// Directed and randomized bench for armleocpu_writeback against a behavioural model.
`timescale 1ns/1ps
module tb_armleocpu_writeback;
    localparam int LIMIT = 4;

    logic        clk;
    logic        rst;
    logic        exe_valid, exe_ready;
    logic [4:0]  exe_rd;
    logic [31:0] exe_wdata;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_wdata;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_regfile_rdata, rs2_regfile_rdata;
    logic [31:0] rs1_rdata, rs2_rdata;
    logic        rs1_busy, rs2_busy;
    logic        sb_conflict;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        rd_write;

    armleocpu_writeback #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_rd(exe_rd), .exe_wdata(exe_wdata),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wdata(lsu_wdata),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_regfile_rdata(rs1_regfile_rdata), .rs2_regfile_rdata(rs2_regfile_rdata),
        .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .sb_conflict(sb_conflict),
        .rd_addr(rd_addr), .rd_wdata(rd_wdata), .rd_write(rd_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: set of pending registers, a starvation count,
    // and the write that should currently sit on the regfile port.
    bit          busy_m[32];
    int          starve_m;
    bit          exp_wr;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    bit          exp_conf;
    bit          m_exe_ready, m_lsu_ready;
    bit          exe_acc, lsu_acc;
    int          pass_cnt = 0;
    int          total    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
            $error("check %s", tag);
        end
    endtask

    // Combinational checks, sampled mid-cycle after inputs settle.
    task automatic pre();
        logic [31:0] f1, f2;
        #1;
        m_lsu_ready = !exe_valid || (starve_m == LIMIT);
        m_exe_ready = !(lsu_valid && (starve_m == LIMIT));
        f1 = (exp_wr && exp_addr == rs1_addr && rs1_addr != 0) ? exp_data : rs1_regfile_rdata;
        f2 = (exp_wr && exp_addr == rs2_addr && rs2_addr != 0) ? exp_data : rs2_regfile_rdata;
        check("exe_ready", 32'(exe_ready), 32'(m_exe_ready));
        check("lsu_ready", 32'(lsu_ready), 32'(m_lsu_ready));
        check("rs1_busy", 32'(rs1_busy), 32'(busy_m[rs1_addr]));
        check("rs2_busy", 32'(rs2_busy), 32'(busy_m[rs2_addr]));
        check("rs1_rdata", rs1_rdata, f1);
        check("rs2_rdata", rs2_rdata, f2);
    endtask

    // Advance one edge, update the model from pre-edge inputs, check registered outputs.
    task automatic post();
        @(posedge clk);
        exe_acc = exe_valid && m_exe_ready && !rst;
        lsu_acc = lsu_valid && m_lsu_ready && !rst;
        if (rst) begin
            exp_wr = 0; exp_addr = '0; exp_data = '0; exp_conf = 0; starve_m = 0;
            foreach (busy_m[i]) busy_m[i] = 0;
        end else begin
            exp_wr = 0;
            if (lsu_acc) begin
                exp_wr = (lsu_rd != 0); exp_addr = lsu_rd; exp_data = lsu_wdata;
            end else if (exe_acc) begin
                exp_wr = (exe_rd != 0); exp_addr = exe_rd; exp_data = exe_wdata;
            end
            exp_conf = issue_valid && issue_rd != 0 && busy_m[issue_rd];
            if (lsu_acc && lsu_rd != 0) busy_m[lsu_rd] = 0;
            if (issue_valid && issue_rd != 0) busy_m[issue_rd] = 1;
            if (lsu_acc) starve_m = 0;
            else if (lsu_valid && !m_lsu_ready && starve_m < LIMIT) starve_m++;
        end
        #1;
        check("rd_write", 32'(rd_write), 32'(exp_wr));
        check("sb_conflict", 32'(sb_conflict), 32'(exp_conf));
        if (exp_wr) begin
            check("rd_addr", 32'(rd_addr), 32'(exp_addr));
            check("rd_wdata", rd_wdata, exp_data);
        end
    endtask

    task automatic step();
        pre();
        post();
    endtask

    task automatic idle();
        exe_valid = 0; lsu_valid = 0; issue_valid = 0;
    endtask

    initial begin
        rst = 1; exe_valid = 1; lsu_valid = 1; issue_valid = 1;
        exe_rd = 5'd3; exe_wdata = 32'h1111_1111; lsu_rd = 5'd4; lsu_wdata = 32'h2222_2222;
        issue_rd = 5'd6; rs1_addr = 0; rs2_addr = 0;
        rs1_regfile_rdata = 32'h0; rs2_regfile_rdata = 32'h0;
        exp_wr = 0; exp_addr = 0; exp_data = 0; exp_conf = 0; starve_m = 0;
        m_exe_ready = 0; m_lsu_ready = 0;

        // Reset held two cycles with every valid asserted
        #1;
        post();
        step();
        rst = 0; idle();
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_rd_wdata", rd_wdata, 32'd0);
        for (int i = 0; i < 16; i++) begin
            rs1_addr = 5'(2 * i); rs2_addr = 5'(2 * i + 1);
            pre();
            check("rst_busy_scan", 32'({rs1_busy, rs2_busy}), 32'd0);
            post();
        end

        // exe only, then forwarding of the write stage
        exe_valid = 1; exe_rd = 5'd5; exe_wdata = 32'hDEAD_BEEF;
        pre();
        check("exe_only_ready", 32'(exe_ready), 32'd1);
        post();
        check("exe_only_rd_write", 32'(rd_write), 32'd1);
        check("exe_only_rd_addr", 32'(rd_addr), 32'd5);
        exe_valid = 0; rs1_addr = 5'd5; rs1_regfile_rdata = 32'h1234_5678;
        pre();
        check("exe_only_fwd", rs1_rdata, 32'hDEAD_BEEF);
        post();

        // Contention: lsu waits LIMIT cycles, then wins one cycle
        exe_valid = 1; exe_rd = 5'd2; exe_wdata = 32'h0000_0E0E;
        lsu_valid = 1; lsu_rd = 5'd7; lsu_wdata = 32'hCAFE_0007;
        for (int i = 0; i <= LIMIT; i++) begin
            pre();
            check("contend_lsu_ready", 32'(lsu_ready), 32'(i == LIMIT));
            check("contend_exe_ready", 32'(exe_ready), 32'(i != LIMIT));
            post();
        end
        check("contend_lsu_rd_addr", 32'(rd_addr), 32'd7);
        check("contend_lsu_wdata", rd_wdata, 32'hCAFE_0007);
        pre();
        check("contend_exe_resume", 32'(exe_ready), 32'd1);
        check("contend_cnt_cleared", 32'(lsu_ready), 32'd0);
        post();
        idle();
        step();

        // Scoreboard set / hold / conflict / clear
        issue_valid = 1; issue_rd = 5'd9;
        step();
        issue_valid = 0; rs2_addr = 5'd9;
        for (int i = 0; i < 3; i++) begin
            pre();
            check("sb_busy_hold", 32'(rs2_busy), 32'd1);
            post();
        end
        issue_valid = 1;
        step();
        check("sb_conflict_pulse", 32'(sb_conflict), 32'd1);
        issue_valid = 0;
        step();
        check("sb_conflict_drop", 32'(sb_conflict), 32'd0);
        issue_valid = 1; lsu_valid = 1; lsu_rd = 5'd9; lsu_wdata = 32'h0909_0909;
        step();
        idle();
        pre();
        check("sb_set_wins", 32'(rs2_busy), 32'd1);
        post();
        lsu_valid = 1;
        step();
        idle();
        pre();
        check("sb_cleared", 32'(rs2_busy), 32'd0);
        post();

        // x0 destination
        exe_valid = 1; exe_rd = 5'd0; exe_wdata = 32'hFFFF_FFFF; issue_valid = 1; issue_rd = 5'd0;
        step();
        check("x0_no_write", 32'(rd_write), 32'd0);
        idle(); rs1_addr = 5'd0; rs1_regfile_rdata = 32'hA5A5_0000;
        pre();
        check("x0_busy", 32'(rs1_busy), 32'd0);
        check("x0_rdata", rs1_rdata, 32'hA5A5_0000);
        post();

        // Randomized traffic honouring the hold-until-accepted rule
        exe_acc = 1; lsu_acc = 1;
        for (int c = 0; c < 400; c++) begin
            if (!exe_valid || exe_acc) begin
                exe_valid = ($urandom_range(0, 3) != 0);
                exe_rd = 5'($urandom_range(0, 7)); exe_wdata = $urandom;
            end
            if (!lsu_valid || lsu_acc) begin
                lsu_valid = ($urandom_range(0, 2) != 0);
                lsu_rd = 5'($urandom_range(0, 7)); lsu_wdata = $urandom;
            end
            issue_valid = ($urandom_range(0, 3) == 0);
            issue_rd = 5'($urandom_range(0, 7));
            rs1_addr = 5'($urandom_range(0, 7)); rs2_addr = 5'($urandom_range(0, 7));
            rs1_regfile_rdata = $urandom; rs2_regfile_rdata = $urandom;
            step();
        end

        // Reset in the cycle after a transfer
        idle(); issue_valid = 1; issue_rd = 5'd12;
        step();
        idle(); exe_valid = 1; exe_rd = 5'd3; exe_wdata = 32'h3333_3333;
        step();
        check("midrst_write_before", 32'(rd_write), 32'd1);
        idle(); rst = 1;
        step();
        check("midrst_write_dropped", 32'(rd_write), 32'd0);
        rst = 0; rs1_addr = 5'd12;
        pre();
        check("midrst_busy_cleared", 32'(rs1_busy), 32'd0);
        post();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
